// File: rtl/dmem_pkg.sv
// Shared types and defaults for the MEM-stage data memory responder.
// Build option: DMEM_RESET_INIT_EN (see dmem_ram).
package dmem_pkg;

    localparam int DMEM_DEFAULT_DEPTH   = 1024;
    localparam int DMEM_DEFAULT_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

endpackage

// File: rtl/dmem_ram.sv
// Word array with byte-enable write and combinational read.
// DMEM_RESET_INIT_EN: when defined, reset loads word i with value i.
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] idx,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem_q [DEPTH];

    assign rdata = mem_q[idx];

`ifdef DMEM_RESET_INIT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'(i);
            end
        end else if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
`else
    // A store caught by reset must not land, so reset still gates the write.
    always_ff @(posedge clk) begin
        if (we && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end
`endif

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding load/store responder with programmable wait cycles,
// byte-enable stores and misaligned/out-of-range error reporting.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = DMEM_DEFAULT_DEPTH,
    parameter int LATENCY = DMEM_DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    dmem_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    dmem_req_t   req_q, req_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;

    dmem_req_t   acc;
    logic        accept;
    logic        fire;
    logic        acc_err;
    logic        ram_we;
    logic [31:0] ram_rdata;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            req_q       <= '0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_q       <= req_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) state_d = RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Access datapath: with zero latency the access uses the request as it arrives
    always_comb begin
        accept = (state_q == IDLE) && req_valid;
        req_d  = req_q;
        if (accept) begin
            req_d.write = req_write;
            req_d.addr  = req_addr;
            req_d.wdata = req_wdata;
            req_d.be    = req_be;
        end
        acc  = accept ? req_d : req_q;
        fire = (accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == 4'd0));

        acc_err = (acc.addr[1:0] != 2'b00) || ((acc.addr >> (AW + 2)) != 32'd0);
        ram_we  = fire && acc.write && !acc_err;

        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (fire) begin
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_err || acc.write) ? 32'd0 : ram_rdata;
        end
    end

    // Outputs
    always_comb begin
        req_ready = (state_q == IDLE) && !reset;
        rsp_valid = (state_q == RESP);
        rsp_rdata = rsp_rdata_q;
        rsp_err   = rsp_err_q;
    end

    dmem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .be    (acc.be),
        .idx   (acc.addr[AW+1:2]),
        .wdata (acc.wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: u0 (LATENCY=2, DEPTH=1024), u1 (LATENCY=4, DEPTH=64),
// u2 (LATENCY=0, DEPTH=64), sharing clock and reset.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid [3];
    logic        req_ready [3];
    logic        req_write [3];
    logic [31:0] req_addr  [3];
    logic [31:0] req_wdata [3];
    logic [3:0]  req_be    [3];
    logic        rsp_valid [3];
    logic        rsp_ready [3];
    logic [31:0] rsp_rdata [3];
    logic        rsp_err   [3];

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.DEPTH(1024), .LATENCY(2)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(64), .LATENCY(4)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dmem_responder #(.DEPTH(64), .LATENCY(0)) u2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_write(req_write[2]),
        .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]),
        .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic chk1(input string name, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    // Returns at the negedge of the accept cycle (ready seen while valid held).
    task automatic wait_accept(input int w);
        int n;
        n = 0;
        while (!req_ready[w] && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk1("accept_seen", req_ready[w], 1'b1);
    endtask

    // Counts cycles from the accept cycle until rsp_valid is observed.
    task automatic wait_rsp(input int w, output int lat);
        lat = 1;
        @(negedge clk);
        while (!rsp_valid[w] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic txn(input int w, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] be, output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        req_valid[w] = 1'b1;
        req_write[w] = wr;
        req_addr[w]  = a;
        req_wdata[w] = d;
        req_be[w]    = be;
        wait_accept(w);
        wait_rsp(w, lat);
        rd = rsp_rdata[w];
        er = rsp_err[w];
        // Scramble request inputs while in flight; they must be ignored.
        req_valid[w] = 1'b0;
        req_write[w] = ~wr;
        req_addr[w]  = 32'hDEAD_BEEF;
        req_wdata[w] = 32'hFFFF_FFFF;
        req_be[w]    = 4'hF;
    endtask

    task automatic check_txn(input string tag, input int w, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] be,
                             input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        logic [31:0] rd;
        logic        er;
        int          lat;
        txn(w, wr, a, d, be, rd, er, lat);
        chk32({tag, "_rdata"}, rd, exp_rd);
        chk1({tag, "_err"}, er, exp_err);
        chk32({tag, "_lat"}, lat, exp_lat);
    endtask

    initial begin
        logic        l0_wr  [5];
        logic [31:0] l0_a   [5];
        logic [31:0] l0_d   [5];
        logic [31:0] l0_rd  [5];
        logic        l0_err [5];
        logic [31:0] exp_w16;
        int          lat;

        l0_wr  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        l0_a   = '{32'h0C, 32'h10, 32'h0C, 32'h10, 32'h100};
        l0_d   = '{32'h1111_1111, 32'h2222_2222, 32'h0, 32'h0, 32'h0};
        l0_rd  = '{32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222, 32'h0};
        l0_err = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b1;
        for (int w = 0; w < 3; w++) begin
            req_valid[w] = 1'b0;
            req_write[w] = 1'b0;
            req_addr[w]  = 32'd0;
            req_wdata[w] = 32'd0;
            req_be[w]    = 4'd0;
            rsp_ready[w] = 1'b1;
        end

        // Reset cycle
        @(negedge clk);
        chk1("rst_req_ready", req_ready[0], 1'b0);
        chk1("rst_rsp_valid", rsp_valid[0], 1'b0);
        chk32("rst_rsp_rdata", rsp_rdata[0], 32'd0);
        chk1("rst_rsp_err", rsp_err[0], 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk1("post_rst_req_ready", req_ready[0], 1'b1);

        // Basic load
`ifdef DMEM_RESET_INIT_EN
        check_txn("init_load", 0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0000_0004, 1'b0, 3);
`else
        check_txn("seed_store", 0, 1'b1, 32'h10, 32'h4, 4'hF, 32'h0, 1'b0, 3);
        check_txn("init_load", 0, 1'b0, 32'h10, 32'h0, 4'hF, 32'h0000_0004, 1'b0, 3);
`endif

        // Byte-enable store
        check_txn("clr_store", 0, 1'b1, 32'h20, 32'h0, 4'hF, 32'h0, 1'b0, 3);
        check_txn("be_store", 0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0, 3);
        check_txn("be_load", 0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h00BB_00DD, 1'b0, 3);
        check_txn("be0_store", 0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'h0, 32'h0, 1'b0, 3);
        check_txn("be0_load", 0, 1'b0, 32'h20, 32'h0, 4'hF, 32'h00BB_00DD, 1'b0, 3);

        // Errors and range boundaries
        check_txn("w0_store", 0, 1'b1, 32'h0, 32'h1234_5678, 4'hF, 32'h0, 1'b0, 3);
        check_txn("mis_load", 0, 1'b0, 32'h2, 32'h0, 4'hF, 32'h0, 1'b1, 3);
        check_txn("oor_store", 0, 1'b1, 32'h1000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1, 3);
        check_txn("hi_store", 0, 1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b1, 3);
        check_txn("w0_load", 0, 1'b0, 32'h0, 32'h0, 4'hF, 32'h1234_5678, 1'b0, 3);
        check_txn("top_store", 0, 1'b1, 32'hFFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 3);
        check_txn("top_load", 0, 1'b0, 32'hFFC, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 3);

        // Backpressure: RESP held with outputs frozen, new requests not taken
        @(negedge clk);
        rsp_ready[0] = 1'b0;
        req_valid[0] = 1'b1;
        req_write[0] = 1'b0;
        req_addr[0]  = 32'h20;
        wait_accept(0);
        wait_rsp(0, lat);
        chk32("bp_lat", lat, 3);
        for (int k = 0; k < 5; k++) begin
            req_valid[0] = 1'b1;
            req_addr[0]  = 32'h0;
            chk1("bp_valid", rsp_valid[0], 1'b1);
            chk32("bp_rdata", rsp_rdata[0], 32'h00BB_00DD);
            chk1("bp_err", rsp_err[0], 1'b0);
            chk1("bp_req_ready", req_ready[0], 1'b0);
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        rsp_ready[0] = 1'b1;
        chk1("bp_valid_release", rsp_valid[0], 1'b1);
        @(negedge clk);
        chk1("bp_valid_after", rsp_valid[0], 1'b0);
        chk1("bp_req_ready_after", req_ready[0], 1'b1);

        // Zero latency, req_valid held high across back-to-back transactions
        @(negedge clk);
        req_valid[2] = 1'b1;
        req_be[2]    = 4'hF;
        for (int k = 0; k < 5; k++) begin
            req_write[2] = l0_wr[k];
            req_addr[2]  = l0_a[k];
            req_wdata[2] = l0_d[k];
            chk1("l0_accept", req_ready[2], 1'b1);
            @(negedge clk);
            chk1("l0_rsp_valid", rsp_valid[2], 1'b1);
            chk32("l0_rdata", rsp_rdata[2], l0_rd[k]);
            chk1("l0_err", rsp_err[2], l0_err[k]);
            chk1("l0_resp_req_ready", req_ready[2], 1'b0);
            req_addr[2] = 32'hFFFF_FFFF;
            @(negedge clk);
        end
        req_valid[2] = 1'b0;

        // Reset during WAIT drops a pending store
        check_txn("rst_pre", 1, 1'b1, 32'h40, 32'h5A5A_5A5A, 4'hF, 32'h0, 1'b0, 5);
        @(negedge clk);
        req_valid[1] = 1'b1;
        req_write[1] = 1'b1;
        req_addr[1]  = 32'h40;
        req_wdata[1] = 32'h0BAD_0BAD;
        req_be[1]    = 4'hF;
        wait_accept(1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        chk1("rw_wait1_ready", req_ready[1], 1'b0);
        @(negedge clk);
        chk1("rw_wait2_valid", rsp_valid[1], 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk1("rw_rst_req_ready", req_ready[1], 1'b0);
        chk1("rw_rst_rsp_valid", rsp_valid[1], 1'b0);
        chk32("rw_rst_rsp_rdata", rsp_rdata[1], 32'd0);
        chk1("rw_rst_rsp_err", rsp_err[1], 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk1("rw_idle_ready", req_ready[1], 1'b1);
        chk1("rw_idle_valid", rsp_valid[1], 1'b0);
`ifdef DMEM_RESET_INIT_EN
        exp_w16 = 32'h0000_0010;
`else
        exp_w16 = 32'h5A5A_5A5A;
`endif
        check_txn("rw_load", 1, 1'b0, 32'h40, 32'h0, 4'hF, exp_w16, 1'b0, 5);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
